ahb_rst_seq: RTL and testbench
==============================

# ahb_rst_seq

Reset sequencer sitting directly downstream of the codebase's `Rst_sync` reset synchronizer. It is fed by the top-level inversion of `Rst_sync.sync_rst_n`. It holds the AHB subsystem in reset for a programmable time, then releases the domains in a fixed order: fabric (decoder/mux), then slaves, then masters. It also services a software reset request: it waits for the bus to go idle, with a timeout, before re-asserting all resets.

## Interface
- `HOLD_CYCLES`, default 16: cycles all resets stay asserted before the fabric is released; must be ≥1.
- `STEP_CYCLES`, default 4: spacing between successive domain releases; must be ≥1.
- `TIMEOUT_CYCLES`, default 256: maximum wait for `bus_idle` during a software reset; must be ≥1.
- `clk` input 1: single clock; all logic is on the rising edge.
- `sync_rst` input 1: reset, synchronous, active-high. It overrides everything.
- `sw_rst_req` input 1: level software reset request. Sampled only in RUN.
- `bus_idle` input 1: 1 when no AHB transfer is in flight (HTRANS IDLE and HREADY high).
- `fabric_rst_n` output 1: active-low reset for interconnect.
- `slave_rst_n` output 1: active-low reset for slaves.
- `master_rst_n` output 1: active-low reset for masters.
- `rst_done` output 1: 1 only in RUN.
- `sw_rst_ack` output 1: one-cycle pulse on the edge a software reset asserts the resets.
- `timeout_flag` output 1: sticky; set when a software reset was forced by timeout.

## Operation
- States are HOLD, REL_FABRIC, REL_SLAVE, RUN and QUIESCE. One shared counter `cnt` serves all of them.
- All outputs are registered.
- While `sync_rst`=1:
  - state is HOLD and `cnt`=0.
  - `fabric_rst_n`, `slave_rst_n`, `master_rst_n`, `rst_done`, `sw_rst_ack` and `timeout_flag` are all 0.
- HOLD: counts to `HOLD_CYCLES`. At expiry, `fabric_rst_n`←1, `cnt` clears, and the state moves to REL_FABRIC.
- REL_FABRIC: counts `STEP_CYCLES`. At expiry, `slave_rst_n`←1 and the state moves to REL_SLAVE.
- REL_SLAVE: counts `STEP_CYCLES`. At expiry, `master_rst_n`←1, `rst_done`←1 and the state moves to RUN.
- RUN: all resets are deasserted. `sw_rst_req`=1 sampled moves to QUIESCE, with `rst_done`←0 on that edge. The domain resets stay deasserted.
- QUIESCE: `cnt` counts edges since entry.
  - If `bus_idle` is sampled 1, or `cnt` reaches `TIMEOUT_CYCLES`, the block does all of the following on that edge:
    - drives all three resets to 0;
    - sets `sw_rst_ack`←1 for one cycle;
    - clears `cnt` and enters HOLD.
  - `timeout_flag`←1 only if the exit was by timeout with `bus_idle`=0.
- `sw_rst_req` is ignored in HOLD, REL_FABRIC, REL_SLAVE and QUIESCE. The requester is expected to drop it after seeing `sw_rst_ack`.
- If the request is still high when RUN is re-entered, another software reset begins.
- `timeout_flag` is cleared only by `sync_rst`.

## Timing
Edge 1 is the first rising edge that samples `sync_rst`=0.
- `fabric_rst_n` rises at edge `HOLD_CYCLES`.
- `slave_rst_n` rises at edge `HOLD_CYCLES+STEP_CYCLES`.
- `master_rst_n` and `rst_done` rise at edge `HOLD_CYCLES+2*STEP_CYCLES`. With defaults these are edges 16, 20 and 24.

Software reset, counting the edge that enters QUIESCE as edge 0:
- The resets assert at edge k, the first edge k≥1 that samples `bus_idle`=1.
- Otherwise they assert at edge `TIMEOUT_CYCLES` with `timeout_flag` set.
- The assert edge is then edge 0 of a new HOLD. Release timing is identical to the power-up sequence above, relative to that edge.

Boundary and precedence rules:
- If `bus_idle` goes high exactly at edge `TIMEOUT_CYCLES`, this is a clean exit and `timeout_flag` is not set.
- `bus_idle` is already 1 on the entry edge but is not sampled until edge 1, so the minimum quiesce time is 1 cycle.
- If `sync_rst` is asserted in any state, the next edge forces reset values. A `sw_rst_ack` pulse in flight is suppressed.
- Counter width is `$clog2(max(HOLD_CYCLES, STEP_CYCLES, TIMEOUT_CYCLES)+1)`. The counter saturates and never wraps.

## Structure
- Shared package `ahb_rst_pkg` holds:
  - typedef enum `rst_seq_state_e` {HOLD, REL_FABRIC, REL_SLAVE, RUN, QUIESCE};
  - default localparams `RST_HOLD_DFLT`, `RST_STEP_DFLT` and `RST_TIMEOUT_DFLT`.
- No sub-module. The single counter and FSM are inline. The top level instantiates `Rst_sync` and then `ahb_rst_seq`, with `sync_rst = ~sync_rst_n`.

## Test plan
- Power-up with defaults: `sync_rst` high for 3 cycles, then low. Required: `fabric_rst_n`/`slave_rst_n`/`master_rst_n` rise at edges 16/20/24, and `rst_done`=1 at edge 24.
- Clean software reset: in RUN, hold `sw_rst_req`=1 and raise `bus_idle` at edge 5 after entry. Required: resets go 0 and `sw_rst_ack`=1 for exactly one cycle at edge 5, `timeout_flag`=0, and `fabric_rst_n` rises again 16 edges later.
- Timeout: `TIMEOUT_CYCLES`=8 with `bus_idle` held 0. Required: resets assert at edge 8 and `timeout_flag`=1. The flag stays 1 through the re-sequence until `sync_rst`.
- Timeout tie: `bus_idle` rises exactly at edge `TIMEOUT_CYCLES`. Required: assert at that edge with `timeout_flag`=0.
- Reset mid-operation: pulse `sync_rst` for 1 cycle at edge 18 of power-up, and separately during QUIESCE. Required: all outputs 0 next edge, no `sw_rst_ack`, and sequencing restarts from edge 1.
- Ignored request: pulse `sw_rst_req` during REL_SLAVE. Required: no QUIESCE entry, and `rst_done` rises at edge 24 unaffected.

Source files
------------

// File: rtl/ahb_rst_pkg.sv
// Shared types and defaults for the AHB reset sequencer.
package ahb_rst_pkg;

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        REL_FABRIC = 3'd1,
        REL_SLAVE  = 3'd2,
        RUN        = 3'd3,
        QUIESCE    = 3'd4
    } rst_seq_state_e;

    localparam int RST_HOLD_DFLT    = 16;
    localparam int RST_STEP_DFLT    = 4;
    localparam int RST_TIMEOUT_DFLT = 256;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ahb_rst_seq.sv
// Holds the AHB subsystem in reset, then releases fabric, slaves, masters in order;
// services software reset requests once the bus goes idle or a timeout expires.
module ahb_rst_seq
    import ahb_rst_pkg::*;
#(
    parameter int HOLD_CYCLES    = RST_HOLD_DFLT,
    parameter int STEP_CYCLES    = RST_STEP_DFLT,
    parameter int TIMEOUT_CYCLES = RST_TIMEOUT_DFLT
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic sw_rst_req,
    input  logic bus_idle,
    output logic fabric_rst_n,
    output logic slave_rst_n,
    output logic master_rst_n,
    output logic rst_done,
    output logic sw_rst_ack,
    output logic timeout_flag
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STEP_CYCLES, TIMEOUT_CYCLES) + 1);

    // Each phase expires on the edge where cnt holds (duration-1), so that
    // the expiry lands exactly N edges after the phase was entered.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    rst_seq_state_e   state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             fabric_nxt, slave_nxt, master_nxt, done_nxt, ack_nxt, to_nxt;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_inc;
        fabric_nxt = fabric_rst_n;
        slave_nxt  = slave_rst_n;
        master_nxt = master_rst_n;
        done_nxt   = rst_done;
        ack_nxt    = 1'b0;
        to_nxt     = timeout_flag;
        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    fabric_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = REL_FABRIC;
                end
            end
            REL_FABRIC: begin
                if (cnt == STEP_LAST) begin
                    slave_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REL_SLAVE;
                end
            end
            REL_SLAVE: begin
                if (cnt == STEP_LAST) begin
                    master_nxt = 1'b1;
                    done_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (sw_rst_req) begin
                    done_nxt  = 1'b0;
                    state_nxt = QUIESCE;
                end
            end
            QUIESCE: begin
                // An idle bus on the timeout edge counts as a clean exit.
                if (bus_idle || cnt == TO_LAST) begin
                    fabric_nxt = 1'b0;
                    slave_nxt  = 1'b0;
                    master_nxt = 1'b0;
                    ack_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = HOLD;
                    if (!bus_idle) to_nxt = 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state        <= HOLD;
            cnt          <= '0;
            fabric_rst_n <= 1'b0;
            slave_rst_n  <= 1'b0;
            master_rst_n <= 1'b0;
            rst_done     <= 1'b0;
            sw_rst_ack   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            fabric_rst_n <= fabric_nxt;
            slave_rst_n  <= slave_nxt;
            master_rst_n <= master_nxt;
            rst_done     <= done_nxt;
            sw_rst_ack   <= ack_nxt;
            timeout_flag <= to_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_rst_seq.sv
// Directed bench for ahb_rst_seq: power-up order, software reset exits, reset precedence.
module tb_ahb_rst_seq;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic sync_rst = 1'b1;
    logic sw_rst_req = 1'b0;
    logic bus_idle = 1'b0;
    logic fabric_rst_n, slave_rst_n, master_rst_n, rst_done, sw_rst_ack, timeout_flag;

    int n_chk = 0;
    int n_err = 0;
    bit to_sticky = 1'b0;

    always #5 clk = ~clk;

    ahb_rst_seq #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .sw_rst_req  (sw_rst_req),
        .bus_idle    (bus_idle),
        .fabric_rst_n(fabric_rst_n),
        .slave_rst_n (slave_rst_n),
        .master_rst_n(master_rst_n),
        .rst_done    (rst_done),
        .sw_rst_ack  (sw_rst_ack),
        .timeout_flag(timeout_flag)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {fab,slv,mst,done,ack,to}=%b want %b", tag, act[5:0], exp[5:0]);
        end
    endtask

    function automatic logic [7:0] obs();
        return {2'b00, fabric_rst_n, slave_rst_n, master_rst_n, rst_done, sw_rst_ack, timeout_flag};
    endfunction

    function automatic logic [7:0] vec(input bit f, input bit s, input bit m,
                                       input bit d, input bit a, input bit t);
        return {2'b00, f, s, m, d, a, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge 1 is the first edge after the reset/assert edge; releases at 16/20/24.
    task automatic release_seq(input int n, input int pulse_edge);
        for (int e = 1; e <= n; e++) begin
            step();
            chk($sformatf("rel e%0d", e), obs(),
                vec(e >= 16, e >= 20, e >= 24, e >= 24, 1'b0, to_sticky));
            if (e == pulse_edge) sw_rst_req = 1'b1;
            else if (e == pulse_edge + 1) sw_rst_req = 1'b0;
        end
    endtask

    // idle_edge: first QUIESCE edge sampling bus_idle=1 (0 = already high at entry).
    task automatic sw_reset(input int idle_edge, input bit to_exp);
        int ex;
        ex = (idle_edge < TO) ? idle_edge : TO;
        if (ex < 1) ex = 1;
        sw_rst_req = 1'b1;
        bus_idle = (idle_edge == 0);
        step();
        chk($sformatf("q%0d entry", idle_edge), obs(), vec(1, 1, 1, 0, 0, to_sticky));
        for (int k = 1; k <= ex; k++) begin
            bus_idle = (k >= idle_edge);
            step();
            if (k < ex)
                chk($sformatf("q%0d wait k%0d", idle_edge, k), obs(), vec(1, 1, 1, 0, 0, to_sticky));
            else
                chk($sformatf("q%0d exit k%0d", idle_edge, k), obs(), vec(0, 0, 0, 0, 1, to_exp));
        end
        to_sticky = to_exp;
        sw_rst_req = 1'b0;
        bus_idle = 1'b0;
        release_seq(24, 0);
    endtask

    initial begin
        repeat (3) begin
            step();
            chk("reset", obs(), 8'h00);
        end
        sync_rst = 1'b0;

        // Power-up interrupted at edge 18, then a full sequence with an ignored request.
        release_seq(17, 0);
        sync_rst = 1'b1;
        step();
        chk("mid rst e18", obs(), 8'h00);
        sync_rst = 1'b0;
        release_seq(24, 20);

        sw_reset(5, 1'b0);
        sw_reset(TO, 1'b0);
        sw_reset(0, 1'b0);
        sw_reset(99, 1'b1);
        sw_reset(3, 1'b1);

        // sync_rst during QUIESCE wins over an exit that would otherwise ack.
        sw_rst_req = 1'b1;
        step();
        chk("q2 entry", obs(), vec(1, 1, 1, 0, 0, 1));
        repeat (2) begin
            step();
            chk("q2 wait", obs(), vec(1, 1, 1, 0, 0, 1));
        end
        sync_rst = 1'b1;
        bus_idle = 1'b1;
        sw_rst_req = 1'b0;
        step();
        chk("q2 sync", obs(), 8'h00);
        to_sticky = 1'b0;
        sync_rst = 1'b0;
        bus_idle = 1'b0;
        release_seq(24, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
